xillybus_stream_bridge: RTL

Parametrised channel bridge between the Xillybus core's user FIFO ports and the HLS kernels' valid/ready streams. It provides NUM_CH host-to-FPGA channels and NUM_CH FPGA-to-host channels, each buffered by a DEPTH-entry FIFO. It adds end-of-stream signalling in both directions: host close is mapped to a last-beat flag, and kernel last-beat is mapped to Xillybus EOF. It replaces the hand-wired FIFO instances that previously sat beside the 4x32-bit core.

---
 rtl/xillybus_stream_bridge.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/xillybus_stream_bridge.sv
// xillybus_stream_bridge
//   Bridges the Xillybus core's user FIFO ports to kernel valid/ready
//   streams. Each of NUM_CH channels has one host-to-FPGA FIFO and one
//   FPGA-to-host FIFO, DEPTH entries each. End of stream is carried both
//   ways: a host close turns the final buffered word into m_last, and a
//   kernel s_last beat turns into EOF once the host has read it.
//
// Ports (channel c uses bits [c*DATA_W +: DATA_W] or bit [c]):
//   bus_clk_w / bus_rst_n_w          clock, async active-low reset
//   user_w_wren_w/_data_w/_open_w    host write strobe, data, file open
//   user_w_full_w                    write FIFO full
//   m_valid_w/m_ready_w/m_data_w     kernel-side output stream (FWFT)
//   m_last_w                         head word is last after host close
//   user_r_rden_w/_open_w            host read strobe, file open
//   user_r_data_w                    read data, valid the cycle after rden
//   user_r_empty_w/_eof_w            read FIFO empty, end of file
//   s_valid_w/s_ready_w/s_data_w     kernel-side input stream
//   s_last_w                         kernel marks final word
//   ovf_w                            sticky write overflow

// Per-channel engine: one write FIFO (FWFT) and one read FIFO (registered
// output), fully independent of every other channel.
module xillybus_stream_bridge_ch #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_wren,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_open,
    output logic              w_full,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              r_rden,
    output logic [DATA_W-1:0] r_data,
    output logic              r_empty,
    output logic              r_eof,
    input  logic              r_open,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              ovf
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // ---------------- write side ----------------
    logic [DATA_W-1:0] w_mem_q [DEPTH];
    logic [PW-1:0]     w_wr_ptr_q, w_wr_ptr_d, w_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0]     w_cnt_q, w_cnt_d;
    logic              ovf_q, ovf_d, w_open_prev_q;
    logic              w_push, w_pop;

    // Push is decided on the pre-pop count: a wren at full is always dropped.
    assign w_push  = w_wren && (w_cnt_q != FULL_CNT);
    assign w_pop   = (w_cnt_q != '0) && m_ready;
    assign w_full  = (w_cnt_q == FULL_CNT);
    assign m_valid = (w_cnt_q != '0);
    assign m_data  = w_mem_q[w_rd_ptr_q];
    assign m_last  = !w_open && (w_cnt_q == CW'(1));
    assign ovf     = ovf_q;

    always_comb begin
        w_wr_ptr_d = w_push ? w_wr_ptr_q + PW'(1) : w_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? w_rd_ptr_q + PW'(1) : w_rd_ptr_q;
        w_cnt_d    = w_cnt_q;
        case ({w_push, w_pop})
            2'b10:   w_cnt_d = w_cnt_q + CW'(1);
            2'b01:   w_cnt_d = w_cnt_q - CW'(1);
            default: w_cnt_d = w_cnt_q;
        endcase
        // A new open clears the sticky flag; an overflow in that same cycle wins.
        ovf_d = ovf_q;
        if (w_open && !w_open_prev_q) ovf_d = 1'b0;
        if (w_wren && w_full)         ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push) w_mem_q[w_wr_ptr_q] <= w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_wr_ptr_q    <= '0;
            w_rd_ptr_q    <= '0;
            w_cnt_q       <= '0;
            ovf_q         <= 1'b0;
            w_open_prev_q <= 1'b0;
        end else begin
            w_wr_ptr_q    <= w_wr_ptr_d;
            w_rd_ptr_q    <= w_rd_ptr_d;
            w_cnt_q       <= w_cnt_d;
            ovf_q         <= ovf_d;
            w_open_prev_q <= w_open;
        end
    end

    // ---------------- read side ----------------
    // Each entry stores {last, data}.
    logic [DATA_W:0]   r_mem_q [DEPTH];
    logic [DATA_W:0]   r_head;
    logic [PW-1:0]     r_wr_ptr_q, r_wr_ptr_d, r_rd_ptr_q, r_rd_ptr_d;
    logic [CW-1:0]     r_cnt_q, r_cnt_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              sealed_q, sealed_d, eof_q, eof_d;
    logic              active_q;
    logic              r_push, r_pop;

    // active_q keeps s_ready low through reset and its release cycle.
    assign s_ready = active_q && r_open && !sealed_q && (r_cnt_q != FULL_CNT);
    assign r_push  = s_valid && s_ready;
    assign r_pop   = r_open && r_rden && (r_cnt_q != '0);
    assign r_head  = r_mem_q[r_rd_ptr_q];
    assign r_empty = (r_cnt_q == '0);
    assign r_eof   = eof_q && r_empty;
    assign r_data  = r_data_q;

    always_comb begin
        r_wr_ptr_d = r_push ? r_wr_ptr_q + PW'(1) : r_wr_ptr_q;
        r_rd_ptr_d = r_pop  ? r_rd_ptr_q + PW'(1) : r_rd_ptr_q;
        r_cnt_d    = r_cnt_q;
        case ({r_push, r_pop})
            2'b10:   r_cnt_d = r_cnt_q + CW'(1);
            2'b01:   r_cnt_d = r_cnt_q - CW'(1);
            default: r_cnt_d = r_cnt_q;
        endcase
        sealed_d = sealed_q || (r_push && s_last);
        eof_d    = eof_q || (r_pop && r_head[DATA_W]);
        r_data_d = r_pop ? r_head[DATA_W-1:0] : r_data_q;
        // Host side closed: hold the FIFO empty and forget stream state.
        if (!r_open) begin
            r_wr_ptr_d = '0;
            r_rd_ptr_d = '0;
            r_cnt_d    = '0;
            sealed_d   = 1'b0;
            eof_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_push) r_mem_q[r_wr_ptr_q] <= {s_last, s_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_cnt_q    <= '0;
            r_data_q   <= '0;
            sealed_q   <= 1'b0;
            eof_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            r_cnt_q    <= r_cnt_d;
            r_data_q   <= r_data_d;
            sealed_q   <= sealed_d;
            eof_q      <= eof_d;
            active_q   <= 1'b1;
        end
    end
endmodule

module xillybus_stream_bridge #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16
) (
    input  logic                     bus_clk_w,
    input  logic                     bus_rst_n_w,
    input  logic [NUM_CH-1:0]        user_w_wren_w,
    input  logic [NUM_CH*DATA_W-1:0] user_w_data_w,
    input  logic [NUM_CH-1:0]        user_w_open_w,
    output logic [NUM_CH-1:0]        user_w_full_w,
    output logic [NUM_CH-1:0]        m_valid_w,
    input  logic [NUM_CH-1:0]        m_ready_w,
    output logic [NUM_CH*DATA_W-1:0] m_data_w,
    output logic [NUM_CH-1:0]        m_last_w,
    input  logic [NUM_CH-1:0]        user_r_rden_w,
    output logic [NUM_CH*DATA_W-1:0] user_r_data_w,
    output logic [NUM_CH-1:0]        user_r_empty_w,
    output logic [NUM_CH-1:0]        user_r_eof_w,
    input  logic [NUM_CH-1:0]        user_r_open_w,
    input  logic [NUM_CH-1:0]        s_valid_w,
    output logic [NUM_CH-1:0]        s_ready_w,
    input  logic [NUM_CH*DATA_W-1:0] s_data_w,
    input  logic [NUM_CH-1:0]        s_last_w,
    output logic [NUM_CH-1:0]        ovf_w
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        xillybus_stream_bridge_ch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch (
            .clk     (bus_clk_w),
            .rst_n   (bus_rst_n_w),
            .w_wren  (user_w_wren_w[c]),
            .w_data  (user_w_data_w[c*DATA_W +: DATA_W]),
            .w_open  (user_w_open_w[c]),
            .w_full  (user_w_full_w[c]),
            .m_valid (m_valid_w[c]),
            .m_ready (m_ready_w[c]),
            .m_data  (m_data_w[c*DATA_W +: DATA_W]),
            .m_last  (m_last_w[c]),
            .r_rden  (user_r_rden_w[c]),
            .r_data  (user_r_data_w[c*DATA_W +: DATA_W]),
            .r_empty (user_r_empty_w[c]),
            .r_eof   (user_r_eof_w[c]),
            .r_open  (user_r_open_w[c]),
            .s_valid (s_valid_w[c]),
            .s_ready (s_ready_w[c]),
            .s_data  (s_data_w[c*DATA_W +: DATA_W]),
            .s_last  (s_last_w[c]),
            .ovf     (ovf_w[c])
        );
    end
endmodule
